io_stall_ctrl: RTL and testbench
================================

Name: io_stall_ctrl

Overview:
- Multi-cycle sequencer for the two I/O opcodes decoded by the processor control unit: keyboard read (input_ack, op 01110) and LCD write (LCD_wren, op 01111).
- Holds the core with `stall` (freezes PC and register-file write) while it handshakes with the keyboard FIFO or the LCD.
- Releases the instruction for exactly one retire cycle when the transfer completes.
- Sits between the control decoder, the datapath writeback mux and the I/O peripherals.

Parameters:
- LCD_GAP, 4, minimum idle cycles the LCD needs after each write strobe.
- WAIT_MAX, 1024, cycles an LCD write may wait on lcd_busy before it is dropped.
- CNT_W, 10, width of the wait timer and gap counter; must hold max(WAIT_MAX-1, LCD_GAP).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- input_ack_req  in  1  decoded keyboard-read opcode for the current instruction.
- lcd_wren_req  in  1  decoded LCD-write opcode for the current instruction.
- lcd_data_in  in  8  character to write (low byte of the source register).
- kb_valid  in  1  keyboard FIFO has a byte available.
- kb_data  in  8  keyboard FIFO head byte.
- lcd_busy  in  1  LCD controller cannot accept a write.
- err_clr  in  1  clears timeout_err.
- stall  out  1  freeze PC and suppress writeback.
- kb_ack  out  1  one-cycle pop strobe to the keyboard FIFO.
- rd_valid  out  1  writeback enable for the keyboard result.
- kb_rdata  out  32  {24'b0, captured byte}.
- lcd_we  out  1  one-cycle LCD write strobe.
- lcd_data  out  8  registered LCD character.
- timeout_err  out  1  sticky flag: an LCD write was dropped.

Behaviour:
- Reset values (asynchronous on resetn=0):
  - state=IDLE.
  - stall, kb_ack, rd_valid, lcd_we, timeout_err = 0.
  - kb_rdata = 0, lcd_data = 0.
  - Timer and gap counter = 0.
- States: IDLE, KB_WAIT, KB_DONE, LCD_WAIT, LCD_DONE.
- IDLE:
  - stall = input_ack_req | lcd_wren_req, combinational.
  - input_ack_req -> KB_WAIT. input_ack_req has priority if both requests are high (an illegal case).
  - lcd_wren_req -> LCD_WAIT; the timer clears to 0.
- KB_WAIT:
  - stall=1.
  - If kb_valid: kb_ack=1 for this cycle, latch kb_data, -> KB_DONE.
  - Otherwise wait indefinitely (blocking read, no timeout).
- KB_DONE:
  - stall=0, rd_valid=1, kb_rdata = zero-extended latched byte.
  - Requests are ignored this cycle, because they belong to the retiring instruction.
  - -> IDLE.
- LCD_WAIT:
  - stall=1.
  - If !lcd_busy and gap==0: lcd_we=1 with lcd_data = lcd_data_in, captured the same edge; reload gap to LCD_GAP; -> LCD_DONE.
  - Else if timer==WAIT_MAX-1: set timeout_err, no strobe, -> LCD_DONE.
  - Else timer increments.
  - A write takes priority over a timeout in the same cycle.
- LCD_DONE: stall=0, requests ignored, -> IDLE.
- Gap counter:
  - Decrements by 1 every cycle while nonzero, in every state, and saturates at 0.
  - Consequence: consecutive lcd_we pulses are at least LCD_GAP+1 cycles apart.
- timeout_err:
  - Set has priority over err_clr.
  - Otherwise err_clr clears it on the next edge.
- kb_ack, lcd_we and rd_valid are never high more than one cycle per instruction.
- kb_rdata and lcd_data hold their values between transfers.
- Best-case latency, keyboard: 3 cycles (IDLE stall, KB_WAIT ack, KB_DONE retire).
- Best-case latency, LCD: 3 cycles.
- Reset mid-operation:
  - Immediate return to IDLE; all strobes drop.
  - No kb_ack is issued for the pending read.
  - The gap counter clears.

Decomposition:
- Package io_stall_pkg holds:
  - The state enum (3-bit encoding).
  - The opcode constants OP_INPUT=5'b01110 and OP_LCD=5'b01111.
  - Default LCD_GAP, WAIT_MAX, CNT_W.
- One sub-module, lcd_gap_counter: a loadable saturating down-counter with zero flag. It is reused for the gap counter; the wait timer stays inline.

Test Plan:
- Reset: assert resetn=0 mid-clock with inputs toggling -> all outputs 0 immediately; after release, stall=0 with no requests.
- Keyboard read, data present: kb_valid=1, kb_data=8'h41, input_ack_req held -> stall high for 2 cycles; kb_ack pulses once in the KB_WAIT cycle; next cycle rd_valid=1, stall=0, kb_rdata=32'h00000041.
- Blocking read: kb_valid low for 10 cycles, then high with 8'h7A -> stall high for 11 cycles; single kb_ack; rd_valid next cycle with 32'h0000007A.
- LCD back-to-back writes, LCD_GAP=4: write 8'h48 then 8'h49 with lcd_busy=0 -> two lcd_we pulses exactly 5 cycles apart, lcd_data 8'h48 then 8'h49.
- LCD timeout, WAIT_MAX=16: lcd_busy stuck at 1 -> no lcd_we; timeout_err rises after 16 LCD_WAIT cycles; stall drops the following cycle; err_clr clears the flag.
- Reset during KB_WAIT, then kb_valid=1 after release with no request -> no kb_ack, state IDLE, stall=0.

Source files
------------

// File: rtl/io_stall_pkg.sv
// Shared types and defaults for the I/O stall sequencer: FSM encoding,
// the two I/O opcodes it serves, and default timing parameters.
package io_stall_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KB_WAIT  = 3'd1,
    ST_KB_DONE  = 3'd2,
    ST_LCD_WAIT = 3'd3,
    ST_LCD_DONE = 3'd4
  } io_state_e;

  localparam logic [4:0] OP_INPUT = 5'b01110;
  localparam logic [4:0] OP_LCD   = 5'b01111;

  localparam int LCD_GAP_DEF  = 4;
  localparam int WAIT_MAX_DEF = 1024;
  localparam int CNT_W_DEF    = 10;

  function automatic logic is_io_op(input logic [4:0] op);
    return (op == OP_INPUT) || (op == OP_LCD);
  endfunction

endpackage

// File: rtl/lcd_gap_counter.sv
// Loadable down-counter that saturates at zero; used to enforce the idle
// spacing the LCD needs between write strobes.
module lcd_gap_counter #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // A reload wins over the decrement issued in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/io_stall_ctrl.sv
// Stalls the core while a keyboard read or LCD write handshakes with its
// peripheral, then releases the instruction for a single retire cycle.
module io_stall_ctrl
  import io_stall_pkg::*;
#(
  parameter int LCD_GAP  = LCD_GAP_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        input_ack_req,
  input  logic        lcd_wren_req,
  input  logic [7:0]  lcd_data_in,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  input  logic        lcd_busy,
  input  logic        err_clr,
  output logic        stall,
  output logic        kb_ack,
  output logic        rd_valid,
  output logic [31:0] kb_rdata,
  output logic        lcd_we,
  output logic [7:0]  lcd_data,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(LCD_GAP);

  io_state_e        state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       kb_byte_q, kb_byte_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             err_q, err_d;

  logic stall_c, kb_ack_c, rd_valid_c, lcd_we_c;
  logic timeout_set, gap_zero;

  lcd_gap_counter #(.W(CNT_W)) u_gap (
    .clock      (clock),
    .resetn     (resetn),
    .load_i     (lcd_we_c),
    .load_val_i (GAP_LOAD),
    .zero_o     (gap_zero)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    kb_byte_d   = kb_byte_q;
    lcd_data_d  = lcd_data_q;
    stall_c     = 1'b0;
    kb_ack_c    = 1'b0;
    rd_valid_c  = 1'b0;
    lcd_we_c    = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall_c = input_ack_req | lcd_wren_req;
        // Both requests at once is illegal; the keyboard read wins.
        if (input_ack_req) begin
          state_d = ST_KB_WAIT;
        end else if (lcd_wren_req) begin
          state_d = ST_LCD_WAIT;
          timer_d = '0;
        end
      end
      ST_KB_WAIT: begin
        stall_c = 1'b1;
        if (kb_valid) begin
          kb_ack_c  = 1'b1;
          kb_byte_d = kb_data;
          state_d   = ST_KB_DONE;
        end
      end
      ST_KB_DONE: begin
        rd_valid_c = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_LCD_WAIT: begin
        stall_c = 1'b1;
        if (!lcd_busy && gap_zero) begin
          lcd_we_c   = 1'b1;
          lcd_data_d = lcd_data_in;
          state_d    = ST_LCD_DONE;
        end else if (timer_q == TIMER_LAST) begin
          timeout_set = 1'b1;
          state_d     = ST_LCD_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_LCD_DONE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (timeout_set) err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      kb_byte_q  <= '0;
      lcd_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      kb_byte_q  <= kb_byte_d;
      lcd_data_q <= lcd_data_d;
      err_q      <= err_d;
    end
  end

  // The IDLE stall is a straight decode of the requests; mask it so the
  // core sees no stall while reset is held.
  assign stall       = stall_c & resetn;
  assign kb_ack      = kb_ack_c;
  assign rd_valid    = rd_valid_c;
  assign lcd_we      = lcd_we_c;
  assign kb_rdata    = {24'b0, kb_byte_q};
  assign lcd_data    = lcd_data_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_io_stall_ctrl.sv
// Bench for io_stall_ctrl: cycle table plus hand sequences for blocking read,
// LCD timeout and reset mid-transfer; scoreboard queues track read/write data.
module tb_io_stall_ctrl;

  localparam int LCD_GAP  = 4;
  localparam int WAIT_MAX = 16;

  logic        clock = 1'b0;
  logic        resetn;
  logic        input_ack_req, lcd_wren_req, kb_valid, lcd_busy, err_clr;
  logic [7:0]  lcd_data_in, kb_data;
  logic        stall, kb_ack, rd_valid, lcd_we, timeout_err;
  logic [31:0] kb_rdata;
  logic [7:0]  lcd_data;

  io_stall_ctrl #(.LCD_GAP(LCD_GAP), .WAIT_MAX(WAIT_MAX), .CNT_W(10)) dut (
    .clock(clock), .resetn(resetn), .input_ack_req(input_ack_req),
    .lcd_wren_req(lcd_wren_req), .lcd_data_in(lcd_data_in), .kb_valid(kb_valid),
    .kb_data(kb_data), .lcd_busy(lcd_busy), .err_clr(err_clr), .stall(stall),
    .kb_ack(kb_ack), .rd_valid(rd_valid), .kb_rdata(kb_rdata), .lcd_we(lcd_we),
    .lcd_data(lcd_data), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [7:0] kb_q[$];
  logic [7:0] lcd_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       ack, wr, kbv;
    logic [7:0] kbd, din;
    logic       busy, clr;
    logic       e_stall, e_kbak, e_rdv;
    logic [7:0] e_rdat;
    logic       e_we;
    logic [7:0] e_ldat;
    logic       e_err;
  } vec_t;

  function automatic vec_t mk(logic ack, logic wr, logic kbv, logic [7:0] kbd,
                              logic [7:0] din, logic busy, logic clr,
                              logic st, logic ka, logic rv, logic [7:0] rd,
                              logic we, logic [7:0] ld, logic er);
    vec_t v;
    v.ack = ack; v.wr = wr; v.kbv = kbv; v.kbd = kbd; v.din = din;
    v.busy = busy; v.clr = clr; v.e_stall = st; v.e_kbak = ka; v.e_rdv = rv;
    v.e_rdat = rd; v.e_we = we; v.e_ldat = ld; v.e_err = er;
    return v;
  endfunction

  // Monitor: scoreboard pops on rd_valid / the cycle after lcd_we, plus strobe rules.
  int   cyc_n = 0;
  int   last_we = -1;
  logic lcd_pend = 1'b0;
  logic prev_ack = 1'b0;
  initial forever begin
    @(negedge clock);
    cyc_n++;
    if (lcd_pend) begin
      lcd_pend = 1'b0;
      if (lcd_q.size() == 0) chk("mon.lcd_pending", lcd_q.size(), 1);
      else chk("mon.lcd_data", {24'b0, lcd_data}, {24'b0, lcd_q.pop_front()});
    end
    if (rd_valid) begin
      if (kb_q.size() == 0) chk("mon.kb_pending", kb_q.size(), 1);
      else chk("mon.kb_rdata", kb_rdata, {24'b0, kb_q.pop_front()});
    end
    if (kb_ack) chk("mon.kb_ack_single", prev_ack, 0);
    prev_ack = kb_ack;
    if (!resetn) last_we = -1;
    if (lcd_we) begin
      if (last_we >= 0) chk("mon.lcd_gap_ok", (cyc_n - last_we) >= LCD_GAP + 1, 1);
      last_we  = cyc_n;
      lcd_pend = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached without finishing", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic next_cyc();
    @(posedge clock); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stall"}, stall, 0);
    chk({tag, ".kb_ack"}, kb_ack, 0);
    chk({tag, ".rd_valid"}, rd_valid, 0);
    chk({tag, ".kb_rdata"}, kb_rdata, 0);
    chk({tag, ".lcd_we"}, lcd_we, 0);
    chk({tag, ".lcd_data"}, {24'b0, lcd_data}, 0);
    chk({tag, ".timeout_err"}, timeout_err, 0);
  endtask

  task automatic lcd_timeout(input logic clr, input string tag);
    int n_st = 0, n_we = 0, rise = -1;
    lcd_wren_req = 1; lcd_busy = 1; lcd_data_in = 8'h55; err_clr = clr;
    for (int i = 0; i < 40 && rise < 0; i++) begin
      @(negedge clock);
      if (stall) n_st++;
      if (lcd_we) n_we++;
      if (timeout_err) begin
        rise = i;
        chk({tag, ".stall_at_err"}, stall, 0);
      end
      next_cyc();
    end
    lcd_wren_req = 0; lcd_busy = 0;
    chk({tag, ".err_rise_cycle"}, rise, WAIT_MAX + 1);
    chk({tag, ".stall_cycles"}, n_st, WAIT_MAX + 1);
    chk({tag, ".no_lcd_we"}, n_we, 0);
  endtask

  vec_t tbl[23];

  initial begin
    tbl[0]  = mk(0,0,0,8'h00,8'h00,0,0, 0,0,0,8'h00,0,8'h00,0);
    tbl[1]  = mk(1,0,1,8'h41,8'h00,0,0, 1,0,0,8'h00,0,8'h00,0);
    tbl[2]  = mk(1,0,1,8'h41,8'h00,0,0, 1,1,0,8'h00,0,8'h00,0);
    tbl[3]  = mk(1,0,1,8'h41,8'h00,0,0, 0,0,1,8'h41,0,8'h00,0);
    tbl[4]  = mk(0,0,1,8'h41,8'h00,0,0, 0,0,0,8'h41,0,8'h00,0);
    tbl[5]  = mk(0,1,0,8'h00,8'h48,0,0, 1,0,0,8'h41,0,8'h00,0);
    tbl[6]  = mk(0,1,0,8'h00,8'h48,0,0, 1,0,0,8'h41,1,8'h00,0);
    tbl[7]  = mk(0,1,0,8'h00,8'h48,0,0, 0,0,0,8'h41,0,8'h48,0);
    tbl[8]  = mk(0,1,0,8'h00,8'h49,0,0, 1,0,0,8'h41,0,8'h48,0);
    tbl[9]  = mk(0,1,0,8'h00,8'h49,0,0, 1,0,0,8'h41,0,8'h48,0);
    tbl[10] = mk(0,1,0,8'h00,8'h49,0,0, 1,0,0,8'h41,0,8'h48,0);
    tbl[11] = mk(0,1,0,8'h00,8'h49,0,0, 1,0,0,8'h41,1,8'h48,0);
    tbl[12] = mk(0,0,0,8'h00,8'h49,0,0, 0,0,0,8'h41,0,8'h49,0);
    tbl[13] = mk(1,1,0,8'h00,8'h00,0,0, 1,0,0,8'h41,0,8'h49,0);
    tbl[14] = mk(1,1,0,8'h00,8'h00,0,0, 1,0,0,8'h41,0,8'h49,0);
    tbl[15] = mk(1,1,1,8'h5A,8'h00,0,0, 1,1,0,8'h41,0,8'h49,0);
    tbl[16] = mk(0,0,0,8'h00,8'h00,0,0, 0,0,1,8'h5A,0,8'h49,0);
    tbl[17] = mk(0,0,0,8'h00,8'h00,0,1, 0,0,0,8'h5A,0,8'h49,0);
    tbl[18] = mk(0,1,0,8'h00,8'h33,1,0, 1,0,0,8'h5A,0,8'h49,0);
    tbl[19] = mk(0,1,0,8'h00,8'h33,1,0, 1,0,0,8'h5A,0,8'h49,0);
    tbl[20] = mk(0,1,0,8'h00,8'h33,1,0, 1,0,0,8'h5A,0,8'h49,0);
    tbl[21] = mk(0,1,0,8'h00,8'h33,0,0, 1,0,0,8'h5A,1,8'h49,0);
    tbl[22] = mk(0,0,0,8'h00,8'h00,0,0, 0,0,0,8'h5A,0,8'h33,0);

    // Reset held with requests toggling: every output must read zero.
    resetn = 0; input_ack_req = 1; lcd_wren_req = 1; kb_valid = 1;
    kb_data = 8'hFF; lcd_data_in = 8'hEE; lcd_busy = 0; err_clr = 0;
    #12;
    chk_all_zero("rst0a");
    input_ack_req = 0; kb_valid = 0; #4;
    chk_all_zero("rst0b");
    lcd_wren_req = 0; kb_data = 0; lcd_data_in = 0;
    #6 resetn = 1;
    next_cyc();

    foreach (tbl[i]) begin
      input_ack_req = tbl[i].ack; lcd_wren_req = tbl[i].wr; kb_valid = tbl[i].kbv;
      kb_data = tbl[i].kbd; lcd_data_in = tbl[i].din; lcd_busy = tbl[i].busy;
      err_clr = tbl[i].clr;
      if (tbl[i].e_kbak) kb_q.push_back(tbl[i].kbd);
      if (tbl[i].e_we) lcd_q.push_back(tbl[i].din);
      @(negedge clock);
      chk($sformatf("v%0d.stall", i), stall, tbl[i].e_stall);
      chk($sformatf("v%0d.kb_ack", i), kb_ack, tbl[i].e_kbak);
      chk($sformatf("v%0d.rd_valid", i), rd_valid, tbl[i].e_rdv);
      chk($sformatf("v%0d.kb_rdata", i), kb_rdata, {24'b0, tbl[i].e_rdat});
      chk($sformatf("v%0d.lcd_we", i), lcd_we, tbl[i].e_we);
      chk($sformatf("v%0d.lcd_data", i), {24'b0, lcd_data}, {24'b0, tbl[i].e_ldat});
      chk($sformatf("v%0d.timeout_err", i), timeout_err, tbl[i].e_err);
      next_cyc();
    end
    err_clr = 0;

    // Blocking read: data shows up after 10 cycles of kb_valid low.
    begin
      int n_st = 0, n_ack = 0;
      logic got = 0;
      input_ack_req = 1; kb_data = 8'h7A;
      kb_q.push_back(8'h7A);
      for (int i = 0; i < 40 && !got; i++) begin
        kb_valid = (i >= 10);
        @(negedge clock);
        if (stall) n_st++;
        if (kb_ack) n_ack++;
        if (rd_valid) got = 1;
        next_cyc();
      end
      input_ack_req = 0; kb_valid = 0;
      chk("blk.rd_valid_seen", got, 1);
      chk("blk.stall_cycles", n_st, 11);
      chk("blk.kb_ack_count", n_ack, 1);
    end

    // Timeout, then err_clr clears on the following edge.
    lcd_timeout(1'b0, "to1");
    err_clr = 1;
    @(negedge clock); chk("to1.err_held_during_clr", timeout_err, 1);
    next_cyc(); err_clr = 0;
    @(negedge clock); chk("to1.err_cleared", timeout_err, 0);
    next_cyc();

    // Timeout with err_clr held high: set wins, then the clear takes it.
    lcd_timeout(1'b1, "to2");
    @(negedge clock); chk("to2.err_cleared_after", timeout_err, 0);
    next_cyc(); err_clr = 0;

    // Reset in KB_WAIT: no pop for the abandoned read once released.
    input_ack_req = 1; kb_valid = 0;
    next_cyc();
    @(negedge clock); chk("rst1.kbwait_stall", stall, 1);
    #2 resetn = 0; kb_valid = 1;
    #1 chk_all_zero("rst1");
    @(posedge clock); #3;
    input_ack_req = 0; resetn = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("rst1.post%0d.stall", i), stall, 0);
      chk($sformatf("rst1.post%0d.kb_ack", i), kb_ack, 0);
      chk($sformatf("rst1.post%0d.rd_valid", i), rd_valid, 0);
    end
    kb_valid = 0;
    next_cyc(); next_cyc();
    chk("end.kb_q_empty", kb_q.size(), 0);
    chk("end.lcd_q_empty", lcd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
